generic_width_unpacker: RTL and testbench
=========================================

Name: generic_width_unpacker

Overview:
- Generic wide-to-narrow stream converter, the read side of the width-packing path that carries 8-bit data_a beats and 16-bit data_b words.
- Accepts one WIDE_WIDTH word on a valid/ready input and emits it as RATIO = WIDE_WIDTH/NARROW_WIDTH narrow beats on a valid/ready output.
- Beat order is fixed per instance by a parameter.
- Instantiated by generic wrappers that specialise the widths.

Parameters:
- NARROW_WIDTH, 8, output beat width in bits (≥1).
- WIDE_WIDTH, 16, input word width in bits. Must be an integer multiple of NARROW_WIDTH with RATIO ≥ 2; any other value is an elaboration error.
- ORDER, 0, beat order: 0 = least-significant slice first (FOO); 1 = most-significant slice first (BAR).

Ports:
- i_clk  input  1  clock; all state on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_flush  input  1  synchronous discard of the word in progress.
- i_wide_valid  input  1  input word valid.
- o_wide_ready  output  1  input word accepted when valid && ready.
- i_wide_data  input  WIDE_WIDTH  input word.
- i_wide_last  input  1  end-of-packet marker for the word.
- o_narrow_valid  output  1  output beat valid.
- i_narrow_ready  input  1  output beat accepted when valid && ready.
- o_narrow_data  output  NARROW_WIDTH  current beat.
- o_narrow_last  output  1  high only on the final beat of a word captured with last=1.
- o_busy  output  1  a word is held (SHIFT state).
- o_beat_idx  output  clog2(RATIO)  index of the beat currently presented.

Behaviour:
- Reset, asynchronous on i_rst_n low:
  - state = IDLE
  - holding register = 0, last flag = 0, beat counter = 0
  - o_narrow_valid = 0, o_narrow_data = 0, o_narrow_last = 0, o_busy = 0, o_beat_idx = 0, o_wide_ready = 0 while reset is asserted.
  - A word in progress is discarded with no partial output.
- State machine (two states):
  - IDLE: o_wide_ready = 1 (unless i_flush). On accept → capture data and last, counter = 0, go to SHIFT.
  - SHIFT: o_narrow_valid = 1. On each narrow accept, counter +1.
  - On accept of beat RATIO-1 with no new word accepted → IDLE.
  - On accept of beat RATIO-1 with a new word accepted the same cycle → stay in SHIFT, capture the new word, counter = 0.
- o_wide_ready in SHIFT = i_narrow_ready && (counter == RATIO-1) && !i_flush. This allows zero-bubble back-to-back words (combinational ready path through i_narrow_ready only).
- Latency: word accepted at edge N → first beat valid in the cycle after edge N. Sustained throughput is 1 beat/cycle.
- Beat selection:
  - ORDER=0: beat k = holding[k*NARROW_WIDTH +: NARROW_WIDTH].
  - ORDER=1: beat k = slice (RATIO-1-k).
  - Counter wraps RATIO-1 → 0 only via word capture or IDLE.
- Stability: while o_narrow_valid && !i_narrow_ready, o_narrow_data, o_narrow_last and o_beat_idx are held stable.
- o_narrow_last = captured last && counter == RATIO-1.
- i_flush:
  - Highest priority. At the next edge → IDLE, counter = 0, valid = 0, held word dropped.
  - o_wide_ready = 0 during the flush cycle, so a simultaneous wide_valid is not accepted.
  - A simultaneous narrow accept still counts as transferred at the sink; no further beats are issued.
- No internal overflow is possible. No input is lost except by flush or reset.

Test Plan:
- Defaults, ORDER=0, sink always ready, word 0xA5C3 with last=0 → beats 0xC3 then 0xA5 on consecutive cycles; o_beat_idx 0,1; o_narrow_last 0; returns to IDLE, o_busy=0.
- Back-to-back 0x1234 then 0xABCD (last=1), source always valid → beats 0x34, 0x12, 0xCD, 0xAB in 4 consecutive cycles; o_wide_ready high in the cycle 0x12 is accepted; o_narrow_last=1 only on 0xAB.
- Backpressure: i_narrow_ready low for 3 cycles on beat 0 of 0xA5C3 → o_narrow_data holds 0xC3 with valid=1 and o_wide_ready=0 throughout; then 0xA5 follows.
- ORDER=1, NARROW=8, WIDE=32, word 0x11223344 → beats 0x11, 0x22, 0x33, 0x44; o_beat_idx 0..3. Repeat with ORDER=0 → 0x44, 0x33, 0x22, 0x11.
- i_flush asserted after beat 0 of 0xA5C3, with i_wide_valid=1 carrying 0x5A5A the same cycle → 0xA5 never appears, 0x5A5A not accepted that cycle; 0x5A5A accepted the next cycle and emitted as 0x5A, 0x5A.
- i_rst_n pulsed low mid-word (after 0xC3) → all outputs 0 asynchronously; after release o_wide_ready=1 and no residual beats from 0xA5C3.

Source files
------------

// File: rtl/generic_width_unpacker.sv
// Wide-to-narrow unpacker: one WIDE_WIDTH word in, RATIO NARROW_WIDTH beats out; first beat the cycle after accept.
// Beats hold stable under sink backpressure; the next word is taken on the last beat's accept for zero-bubble streaming.
module generic_width_unpacker #(
  parameter int NARROW_WIDTH = 8,
  parameter int WIDE_WIDTH   = 16,
  parameter int ORDER        = 0
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_flush,
  input  logic                              i_wide_valid,
  output logic                              o_wide_ready,
  input  logic [WIDE_WIDTH-1:0]             i_wide_data,
  input  logic                              i_wide_last,
  output logic                              o_narrow_valid,
  input  logic                              i_narrow_ready,
  output logic [NARROW_WIDTH-1:0]           o_narrow_data,
  output logic                              o_narrow_last,
  output logic                              o_busy,
  output logic [$clog2(WIDE_WIDTH/NARROW_WIDTH)-1:0] o_beat_idx
);

  localparam int RATIO = WIDE_WIDTH / NARROW_WIDTH;
  localparam int IDX_W = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if ((NARROW_WIDTH < 1) || (WIDE_WIDTH % NARROW_WIDTH != 0) || (RATIO < 2)) begin : g_bad_params
    $error("generic_width_unpacker: WIDE_WIDTH must be a multiple >= 2 of NARROW_WIDTH");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                  state_q, state_d;
  logic [WIDE_WIDTH-1:0]   hold_q;
  logic                    last_q;
  logic [IDX_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        sel_idx;
  logic                    wide_acc;
  logic                    narrow_acc;
  logic                    at_last;
  logic [NARROW_WIDTH-1:0] slices [RATIO];

  assign at_last    = (cnt_q == LAST_IDX);
  assign wide_acc   = i_wide_valid && o_wide_ready;
  assign narrow_acc = o_narrow_valid && i_narrow_ready;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (wide_acc) state_d = SHIFT;
        SHIFT: if (narrow_acc && at_last) state_d = wide_acc ? SHIFT : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic; ready in SHIFT only combines the sink's ready on the final beat
  always_comb begin
    o_wide_ready   = 1'b0;
    o_narrow_valid = 1'b0;
    o_busy         = 1'b0;
    if (i_rst_n && !i_flush) begin
      o_wide_ready = (state_q == IDLE) || (i_narrow_ready && at_last);
    end
    if (state_q == SHIFT) begin
      o_narrow_valid = 1'b1;
      o_busy         = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_q <= '0;
      last_q <= 1'b0;
      cnt_q  <= '0;
    end else if (i_flush) begin
      last_q <= 1'b0;
      cnt_q  <= '0;
    end else if (wide_acc) begin
      hold_q <= i_wide_data;
      last_q <= i_wide_last;
      cnt_q  <= '0;
    end else if (narrow_acc) begin
      cnt_q <= at_last ? '0 : cnt_q + IDX_W'(1);
    end
  end

  for (genvar k = 0; k < RATIO; k++) begin : g_slice
    assign slices[k] = hold_q[k*NARROW_WIDTH +: NARROW_WIDTH];
  end

  assign sel_idx       = (ORDER != 0) ? (LAST_IDX - cnt_q) : cnt_q;
  assign o_narrow_data = slices[sel_idx];
  assign o_narrow_last = o_narrow_valid && last_q && at_last;
  assign o_beat_idx    = cnt_q;

endmodule

// File: tb/tb_generic_width_unpacker.sv
// Directed bench for generic_width_unpacker: 8/16 LSB-first instance plus 8/32 instances in both beat orders.
module tb_generic_width_unpacker;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic        i_wide_valid;
  logic        o_wide_ready;
  logic [15:0] i_wide_data;
  logic        i_wide_last;
  logic        o_narrow_valid;
  logic        i_narrow_ready;
  logic [7:0]  o_narrow_data;
  logic        o_narrow_last;
  logic        o_busy;
  logic [0:0]  o_beat_idx;

  logic        w32_valid;
  logic [31:0] w32_data;
  logic        n32_ready;
  logic        r_wide_ready, f_wide_ready;
  logic        r_valid, f_valid, r_last, f_last, r_busy, f_busy;
  logic [7:0]  r_data, f_data;
  logic [1:0]  r_idx, f_idx;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  generic_width_unpacker dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_wide_valid(i_wide_valid), .o_wide_ready(o_wide_ready),
    .i_wide_data(i_wide_data), .i_wide_last(i_wide_last),
    .o_narrow_valid(o_narrow_valid), .i_narrow_ready(i_narrow_ready),
    .o_narrow_data(o_narrow_data), .o_narrow_last(o_narrow_last),
    .o_busy(o_busy), .o_beat_idx(o_beat_idx)
  );

  generic_width_unpacker #(.NARROW_WIDTH(8), .WIDE_WIDTH(32), .ORDER(1)) dut_msb (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_wide_valid(w32_valid), .o_wide_ready(r_wide_ready),
    .i_wide_data(w32_data), .i_wide_last(1'b0),
    .o_narrow_valid(r_valid), .i_narrow_ready(n32_ready),
    .o_narrow_data(r_data), .o_narrow_last(r_last),
    .o_busy(r_busy), .o_beat_idx(r_idx)
  );

  generic_width_unpacker #(.NARROW_WIDTH(8), .WIDE_WIDTH(32), .ORDER(0)) dut_lsb (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_wide_valid(w32_valid), .o_wide_ready(f_wide_ready),
    .i_wide_data(w32_data), .i_wide_last(1'b0),
    .o_narrow_valid(f_valid), .i_narrow_ready(n32_ready),
    .o_narrow_data(f_data), .o_narrow_last(f_last),
    .o_busy(f_busy), .o_beat_idx(f_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled off-edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [7:0] exp_msb [4];
  logic [7:0] exp_lsb [4];

  initial begin
    exp_msb = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_lsb = '{8'h44, 8'h33, 8'h22, 8'h11};

    i_rst_n = 1'b0; i_flush = 1'b0;
    i_wide_valid = 1'b0; i_wide_data = '0; i_wide_last = 1'b0; i_narrow_ready = 1'b1;
    w32_valid = 1'b0; w32_data = '0; n32_ready = 1'b1;
    #2;
    check("rst_valid", o_narrow_valid, 0);
    check("rst_ready", o_wide_ready, 0);
    check("rst_data",  o_narrow_data, 0);
    check("rst_busy",  o_busy, 0);
    step(); step();
    i_rst_n = 1'b1;
    settle();
    check("idle_ready", o_wide_ready, 1);

    // Single word, LSB first
    i_wide_valid = 1'b1; i_wide_data = 16'hA5C3; i_wide_last = 1'b0;
    step();
    i_wide_valid = 1'b0;
    settle();
    check("t1_b0_data", o_narrow_data, 8'hC3);
    check("t1_b0_idx",  o_beat_idx, 0);
    check("t1_b0_vld",  o_narrow_valid, 1);
    check("t1_b0_wrdy", o_wide_ready, 0);
    step();
    check("t1_b1_data", o_narrow_data, 8'hA5);
    check("t1_b1_idx",  o_beat_idx, 1);
    check("t1_b1_last", o_narrow_last, 0);
    step();
    check("t1_busy", o_busy, 0);
    check("t1_vld",  o_narrow_valid, 0);

    // Back-to-back words with zero bubble
    i_wide_valid = 1'b1; i_wide_data = 16'h1234; i_wide_last = 1'b0;
    step();
    i_wide_data = 16'hABCD; i_wide_last = 1'b1;
    settle();
    check("t2_b0_data", o_narrow_data, 8'h34);
    check("t2_b0_wrdy", o_wide_ready, 0);
    step();
    check("t2_b1_data", o_narrow_data, 8'h12);
    check("t2_b1_wrdy", o_wide_ready, 1);
    check("t2_b1_last", o_narrow_last, 0);
    step();
    i_wide_valid = 1'b0;
    settle();
    check("t2_b2_data", o_narrow_data, 8'hCD);
    check("t2_b2_last", o_narrow_last, 0);
    step();
    check("t2_b3_data", o_narrow_data, 8'hAB);
    check("t2_b3_last", o_narrow_last, 1);
    step();
    check("t2_busy", o_busy, 0);

    // Sink backpressure on beat 0
    i_wide_valid = 1'b1; i_wide_data = 16'hA5C3; i_wide_last = 1'b0;
    step();
    i_wide_valid = 1'b0; i_narrow_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("t3_hold_data", o_narrow_data, 8'hC3);
      check("t3_hold_vld",  o_narrow_valid, 1);
      check("t3_hold_wrdy", o_wide_ready, 0);
      check("t3_hold_idx",  o_beat_idx, 0);
      step();
    end
    i_narrow_ready = 1'b1;
    settle();
    check("t3_b0_data", o_narrow_data, 8'hC3);
    step();
    check("t3_b1_data", o_narrow_data, 8'hA5);
    step();
    check("t3_busy", o_busy, 0);

    // 32-bit words in both beat orders
    w32_valid = 1'b1; w32_data = 32'h11223344;
    step();
    w32_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("t4_msb_data", r_data, exp_msb[k]);
      check("t4_msb_idx",  r_idx, k);
      check("t4_lsb_data", f_data, exp_lsb[k]);
      check("t4_lsb_idx",  f_idx, k);
      step();
    end
    check("t4_msb_busy", r_busy, 0);
    check("t4_lsb_busy", f_busy, 0);

    // Flush after beat 0 with a competing input word
    i_wide_valid = 1'b1; i_wide_data = 16'hA5C3;
    step();
    i_wide_valid = 1'b0;
    settle();
    check("t5_b0_data", o_narrow_data, 8'hC3);
    step();
    i_flush = 1'b1; i_wide_valid = 1'b1; i_wide_data = 16'h5A5A; i_narrow_ready = 1'b0;
    settle();
    check("t5_flush_wrdy", o_wide_ready, 0);
    step();
    i_flush = 1'b0; i_narrow_ready = 1'b1;
    settle();
    check("t5_post_vld",  o_narrow_valid, 0);
    check("t5_post_wrdy", o_wide_ready, 1);
    step();
    i_wide_valid = 1'b0;
    settle();
    check("t5_n0_data", o_narrow_data, 8'h5A);
    check("t5_n0_idx",  o_beat_idx, 0);
    step();
    check("t5_n1_data", o_narrow_data, 8'h5A);
    check("t5_n1_idx",  o_beat_idx, 1);
    step();
    check("t5_busy", o_busy, 0);

    // Asynchronous reset mid-word
    i_wide_valid = 1'b1; i_wide_data = 16'hA5C3;
    step();
    i_wide_valid = 1'b0;
    settle();
    check("t6_b0_data", o_narrow_data, 8'hC3);
    step();
    i_rst_n = 1'b0;
    settle();
    check("t6_rst_vld",  o_narrow_valid, 0);
    check("t6_rst_data", o_narrow_data, 0);
    check("t6_rst_last", o_narrow_last, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_idx",  o_beat_idx, 0);
    check("t6_rst_wrdy", o_wide_ready, 0);
    step();
    i_rst_n = 1'b1;
    settle();
    check("t6_rel_wrdy", o_wide_ready, 1);
    check("t6_rel_vld",  o_narrow_valid, 0);
    step();
    check("t6_after_vld",  o_narrow_valid, 0);
    check("t6_after_busy", o_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
